// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the CPU datapath.
// Carries the decoded instruction fields, the ALU zero flag and the memory
// acks toward the controller, and the strobes, selects and status flags back.
//   master : the controller (multicycle_ctrl)
//   slave  : the datapath / memory side
//   CNT_W  : width of the retired-instruction counter
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             dmem_req;
    logic             dmem_we;
    logic [2:0]       alu_op;
    logic             alu_src_b;
    logic             extsel;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [2:0]       state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, funct, zero, imem_ack, dmem_ack,
        output imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we,
               alu_op, alu_src_b, extsel, reg_write, reg_dst, mem_to_reg,
               state, halted, illegal, retired
    );

    modport slave (
        output op, funct, zero, imem_ack, dmem_ack,
        input  imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we,
               alu_op, alu_src_b, extsel, reg_write, reg_dst, mem_to_reg,
               state, halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU.
// Sequences IF -> ID -> EXE -> MEM -> WB over the shared datapath, runs the
// req/ack handshakes with instruction and data memory and counts retired
// instructions.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_ctrl_if.master (instruction fields, zero flag, memory
//           acks in; strobes, selects, state, halted, illegal, retired out)
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // Instruction class; R-type is split by funct so EXE needs no IR fields.
    typedef enum logic [3:0] {
        C_NONE = 4'd0,
        C_ADD, C_SUB, C_AND, C_OR, C_SLT,
        C_ADDI, C_ANDI, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_ILL
    } cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, dec_cls;
    logic             extsel_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             set_illegal;

    // Combinational decode of the IR fields; only consumed in ID.
    always_comb begin
        dec_cls = C_ILL;
        case (bus.op)
            6'b000000: begin
                case (bus.funct)
                    6'b100000: dec_cls = C_ADD;
                    6'b100010: dec_cls = C_SUB;
                    6'b100100: dec_cls = C_AND;
                    6'b100101: dec_cls = C_OR;
                    6'b101010: dec_cls = C_SLT;
                    default:   dec_cls = C_ILL;
                endcase
            end
            6'b001000: dec_cls = C_ADDI;
            6'b001100: dec_cls = C_ANDI;
            6'b001101: dec_cls = C_ORI;
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: dec_cls = C_BEQ;
            6'b000010: dec_cls = C_J;
            6'b111111: dec_cls = C_HALT;
            default:   dec_cls = C_ILL;
        endcase
    end

    // Next-state and retire decision.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_IF: begin
                if (bus.imem_ack) state_d = S_ID;
            end
            S_ID: begin
                case (dec_cls)
                    C_J: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    C_HALT: state_d = S_HALT;
                    C_ILL: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (cls_q)
                    C_BEQ: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (cls_q == C_SW) begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            cls_q     <= C_NONE;
            extsel_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                cls_q    <= dec_cls;
                extsel_q <= (dec_cls == C_ADDI) || (dec_cls == C_LW) ||
                            (dec_cls == C_SW)   || (dec_cls == C_BEQ);
            end
            if (set_illegal) illegal_q <= 1'b1;
            if (retire)      retired_q <= retired_q + 1'b1;
        end
    end

    // Strobes are gated by rst_n so a reset asserted mid-handshake drops
    // outstanding requests in the same instant, not at the next edge.
    always_comb begin
        bus.imem_req   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.alu_op     = 3'b000;
        bus.alu_src_b  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.halted     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    bus.imem_req = 1'b1;
                    bus.ir_write = bus.imem_ack;
                    bus.pc_write = bus.imem_ack;
                end
                S_ID: begin
                    if (dec_cls == C_J) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'b10;
                    end
                end
                S_EXE: begin
                    case (cls_q)
                        C_SUB:              bus.alu_op = 3'b001;
                        C_AND, C_ANDI:      bus.alu_op = 3'b010;
                        C_OR, C_ORI:        bus.alu_op = 3'b011;
                        C_SLT:              bus.alu_op = 3'b100;
                        C_BEQ: begin
                            bus.alu_op   = 3'b001;
                            bus.pc_write = bus.zero;
                            bus.pc_src   = 2'b01;
                        end
                        default:            bus.alu_op = 3'b000;
                    endcase
                    bus.alu_src_b = (cls_q == C_ADDI) || (cls_q == C_ANDI) ||
                                    (cls_q == C_ORI)  || (cls_q == C_LW)   ||
                                    (cls_q == C_SW);
                end
                S_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = (cls_q == C_SW);
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = (cls_q == C_ADD) || (cls_q == C_SUB) ||
                                     (cls_q == C_AND) || (cls_q == C_OR)  ||
                                     (cls_q == C_SLT);
                    bus.mem_to_reg = (cls_q == C_LW);
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.extsel  = extsel_q;
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction stream and
// ack latencies against an instruction-level reference model.
module tb_multicycle_ctrl;
    localparam int CNT_W = 32;

    localparam int K_R = 0, K_ADDI = 1, K_ANDI = 2, K_ORI = 3, K_LW = 4,
                   K_SW = 5, K_BEQ = 6, K_J = 7, K_HALT = 8, K_ILL = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
    multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [CNT_W-1:0] exp_ret;
    bit               exp_ext;
    bit               exp_ill;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int kind(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'b000000: kind = (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                               f == 6'b100101 || f == 6'b101010) ? K_R : K_ILL;
            6'b001000: kind = K_ADDI;
            6'b001100: kind = K_ANDI;
            6'b001101: kind = K_ORI;
            6'b100011: kind = K_LW;
            6'b101011: kind = K_SW;
            6'b000100: kind = K_BEQ;
            6'b000010: kind = K_J;
            6'b111111: kind = K_HALT;
            default:   kind = K_ILL;
        endcase
    endfunction

    // Expected output bundle per phase, straight from the instruction table:
    // {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, alu_op,
    //  alu_src_b, reg_write, reg_dst, mem_to_reg, halted}
    function automatic logic [14:0] exp_out(input int st, input int k, input logic [5:0] f,
                                            input bit z, input bit iack);
        logic ireq, irw, pcw, dreq, dwe, asb, rw, rd, m2r, hlt;
        logic [1:0] psrc;
        logic [2:0] aop;
        {ireq, irw, pcw, dreq, dwe, asb, rw, rd, m2r, hlt} = '0;
        psrc = 2'b00;
        aop  = 3'b000;
        case (st)
            0: begin ireq = 1; irw = iack; pcw = iack; end
            1: if (k == K_J) begin pcw = 1; psrc = 2'b10; end
            2: begin
                asb = (k == K_ADDI || k == K_ANDI || k == K_ORI || k == K_LW || k == K_SW);
                if (k == K_R) begin
                    case (f)
                        6'b100010: aop = 3'b001;
                        6'b100100: aop = 3'b010;
                        6'b100101: aop = 3'b011;
                        6'b101010: aop = 3'b100;
                        default:   aop = 3'b000;
                    endcase
                end else if (k == K_ANDI) aop = 3'b010;
                else if (k == K_ORI) aop = 3'b011;
                else if (k == K_BEQ) begin aop = 3'b001; pcw = z; psrc = 2'b01; end
            end
            3: begin dreq = 1; dwe = (k == K_SW); end
            4: begin rw = 1; rd = (k == K_R); m2r = (k == K_LW); end
            5: hlt = 1;
            default: ;
        endcase
        exp_out = {ireq, irw, pcw, psrc, dreq, dwe, aop, asb, rw, rd, m2r, hlt};
    endfunction

    function automatic logic [14:0] obs_out();
        obs_out = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.dmem_req,
                   bus.dmem_we, bus.alu_op, bus.alu_src_b, bus.reg_write, bus.reg_dst,
                   bus.mem_to_reg, bus.halted};
    endfunction

    task automatic check_status(input string tag, input int st);
        check({tag, ".state"},   64'(bus.state),   64'(st));
        check({tag, ".retired"}, 64'(bus.retired), 64'(exp_ret));
        check({tag, ".extsel"},  64'(bus.extsel),  64'(exp_ext));
        check({tag, ".illegal"}, 64'(bus.illegal), 64'(exp_ill));
    endtask

    // One clock cycle in phase st. The ack that does not belong to the phase
    // and fields the controller must not depend on are randomized.
    task automatic cyc(input string tag, input int st, input int k, input logic [5:0] op,
                       input logic [5:0] f, input bit z, input bit iack, input bit dack);
        @(negedge clk);
        bus.op       = (st == 0) ? 6'($urandom) : op;
        bus.funct    = (st == 0) ? 6'($urandom) : f;
        bus.zero     = (st == 2) ? z : 1'($urandom);
        bus.imem_ack = (st == 0) ? iack : 1'($urandom);
        bus.dmem_ack = (st == 3) ? dack : 1'($urandom);
        #1;
        check_status(tag, st);
        check({tag, ".outs"}, 64'(obs_out()), 64'(exp_out(st, k, f, z, iack)));
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        exp_ret = '0;
        exp_ext = 0;
        exp_ill = 0;
        check_status(tag, 0);
        check({tag, ".outs"}, 64'(obs_out()), 64'(0));
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    // Runs one instruction through the controller. rst_mem >= 0 pulses reset
    // after that many MEM cycles instead of completing the access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input bit z,
                             input int ilat, input int dlat, input int rst_mem);
        int k;
        k = kind(op, f);
        for (int i = 0; i <= ilat; i++) cyc("IF", 0, k, op, f, z, i == ilat, 0);
        cyc("ID", 1, k, op, f, z, 0, 0);
        exp_ext = (k == K_ADDI || k == K_LW || k == K_SW || k == K_BEQ);
        if (k == K_J) begin exp_ret++; return; end
        if (k == K_HALT) return;
        if (k == K_ILL) begin exp_ill = 1; return; end
        cyc("EXE", 2, k, op, f, z, 0, 0);
        if (k == K_BEQ) begin exp_ret++; return; end
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= dlat; i++) begin
                cyc("MEM", 3, k, op, f, z, 0, (i == dlat) && (rst_mem < 0));
                if (i == rst_mem) begin
                    #2;
                    apply_reset("RSTMEM");
                    return;
                end
            end
            if (k == K_SW) begin exp_ret++; return; end
        end
        cyc("WB", 4, k, op, f, z, 0, 0);
        exp_ret++;
    endtask

    task automatic halt_cycles(input string tag);
        for (int i = 0; i < 3; i++) cyc(tag, 5, K_HALT, 6'd0, 6'd0, 0, 0, 0);
    endtask

    logic [5:0] ops[8];
    logic [5:0] functs[5];

    initial begin
        ops    = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                   6'b100011, 6'b101011, 6'b000100, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bus.op = '0; bus.funct = '0; bus.zero = 0; bus.imem_ack = 0; bus.dmem_ack = 0;
        rst_n = 1'b1;
        #2;
        apply_reset("RST0");

        // Directed sequences from the test plan.
        run_instr(6'b001000, 6'd0, 0, 0, 0, -1);          // addi, zero-wait
        run_instr(6'b001101, 6'd0, 0, 1, 0, -1);          // ori
        run_instr(6'b100011, 6'd0, 0, 0, 3, -1);          // lw, dmem_ack after 3
        run_instr(6'b000100, 6'd0, 1, 0, 0, -1);          // beq taken
        run_instr(6'b000100, 6'd0, 0, 2, 0, -1);          // beq not taken
        run_instr(6'b101011, 6'd0, 0, 0, 2, -1);          // sw
        run_instr(6'b000010, 6'd0, 0, 0, 0, -1);          // j
        for (int i = 0; i < 5; i++) run_instr(6'b000000, functs[i], 0, 0, 0, -1);

        // Random legal instruction stream with random latencies.
        for (int n = 0; n < 200; n++) begin
            run_instr(ops[$urandom_range(0, 7)], functs[$urandom_range(0, 4)],
                      1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        // halt, then illegal op and unsupported R-type funct after reset.
        run_instr(6'b111111, 6'd0, 0, 0, 0, -1);
        halt_cycles("HALT");
        @(negedge clk); #1;
        apply_reset("RST1");
        run_instr(6'b001100, 6'd0, 0, 0, 0, -1);
        run_instr(6'b010001, 6'd0, 0, 0, 0, -1);
        halt_cycles("ILLOP");
        @(negedge clk); #1;
        apply_reset("RST2");
        run_instr(6'b000000, 6'b000111, 0, 1, 0, -1);
        halt_cycles("ILLFN");
        @(negedge clk); #1;
        apply_reset("RST3");

        // Reset mid-MEM with dmem_req high, then spurious dmem_ack in IF.
        run_instr(6'b001000, 6'd0, 0, 0, 0, -1);
        run_instr(6'b100011, 6'd0, 0, 0, 5, 1);
        bus.dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b1;
            #1;
            check_status("SPUR", 0);
            check("SPUR.dmem_req", 64'(bus.dmem_req), 64'(0));
        end
        run_instr(6'b101011, 6'd0, 0, 0, 1, -1);
        run_instr(6'b000000, 6'b101010, 0, 0, 0, -1);
        cyc("END", 0, K_R, 6'd0, 6'd0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
